// File: rtl/display_scan_pkg.sv
// Shared display constants: 6-bit word layout, symbol codes and the scan FSM state type.
// The game FSM imports this same package to build its display words.
package display_pkg;

  localparam int WORD_W     = 6;
  localparam int NUM_DIGITS = 8;

  localparam int EN_BIT   = 5;
  localparam int CODE_MSB = 4;
  localparam int CODE_LSB = 1;
  localparam int DP_BIT   = 0;

  localparam logic [3:0] SYM_L = 4'hA;
  localparam logic [3:0] SYM_J = 4'hB;
  localparam logic [3:0] SYM_U = 4'hC;
  localparam logic [3:0] SYM_P = 4'hD;
  localparam logic [3:0] SYM_E = 4'hE;
  localparam logic [3:0] SYM_R = 4'hF;

  typedef logic [WORD_W-1:0] disp_word_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [3:0] word_code(input disp_word_t w);
    return w[CODE_MSB:CODE_LSB];
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Game-core to display-driver bundle: eight display words in, board pin levels out.
// master = game core side, slave = display_scan.
interface display_scan_if;
  import display_pkg::*;

  disp_word_t d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  modport master (
    output d1, d2, d3, d4, d5, d6, d7, d8,
    input  an, seg, frame_tick
  );

  modport slave (
    input  d1, d2, d3, d4, d5, d6, d7, d8,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Symbol code to active-low segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  // NOTE: a full case plus a default keeps this block free of inferred latches.
  always_comb begin
    seg_n_o = 7'h7F;
    unique case (code_i)
      4'h0:  seg_n_o = 7'h40;
      4'h1:  seg_n_o = 7'h79;
      4'h2:  seg_n_o = 7'h24;
      4'h3:  seg_n_o = 7'h30;
      4'h4:  seg_n_o = 7'h19;
      4'h5:  seg_n_o = 7'h12;
      4'h6:  seg_n_o = 7'h02;
      4'h7:  seg_n_o = 7'h78;
      4'h8:  seg_n_o = 7'h00;
      4'h9:  seg_n_o = 7'h10;
      SYM_L: seg_n_o = 7'h47;
      SYM_J: seg_n_o = 7'h61;
      SYM_U: seg_n_o = 7'h41;
      SYM_P: seg_n_o = 7'h0C;
      SYM_E: seg_n_o = 7'h06;
      SYM_R: seg_n_o = 7'h2F;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Eight-digit 7-segment scanner: per-frame snapshot of the display words,
// per-slot blanking against ghosting, registered active-low pin outputs.
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 100_000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic           clock,
  input  logic           reset,
  display_scan_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  scan_state_t      state_q, state_d;
  disp_word_t       snap_q [NUM_DIGITS];
  disp_word_t       words  [NUM_DIGITS];
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q;

  logic             div_wrap;
  logic             frame_wrap;
  disp_word_t       cur_word;
  logic [6:0]       cur_seg_n;

  assign words[0] = bus.d1;
  assign words[1] = bus.d2;
  assign words[2] = bus.d3;
  assign words[3] = bus.d4;
  assign words[4] = bus.d5;
  assign words[5] = bus.d6;
  assign words[6] = bus.d7;
  assign words[7] = bus.d8;

  assign div_wrap   = (div_q == DIV_W'(CLK_DIV - 1));
  assign frame_wrap = div_wrap && (idx_q == 3'd7);
  assign cur_word   = snap_q[idx_q];

  seg7_decode u_decode (
    .code_i  (word_code(cur_word)),
    .seg_n_o (cur_seg_n)
  );

  always_comb begin
    div_d   = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d   = div_wrap ? idx_q + 3'd1 : idx_q;
    state_d = state_q;
    unique case (state_q)
      BLANK: if (div_q == DIV_W'(BLANK_CYCLES - 1)) state_d = SHOW;
      SHOW:  if (div_wrap)                          state_d = BLANK;
      default:                                      state_d = BLANK;
    endcase
  end

  // Outputs are a function of the current counters; registering them gives the one-cycle lag.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (state_q == SHOW && cur_word[EN_BIT]) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = {cur_word[DP_BIT], cur_seg_n};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= frame_wrap;
    end
  end

  // NOTE: the snapshot bank is reset so digits stay dark until the first frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= '0;
    end else if (frame_wrap) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= words[i];
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed frames from the test plan plus random
// word sets, every cycle compared against an arithmetic model of slot/frame timing.
module tb_display_scan;
  import display_pkg::*;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 8 * CLK_DIV;

  // Reference glyphs, active-low {g,f,e,d,c,b,a}, indexed by symbol code.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h47, 7'h61, 7'h41, 7'h0C, 7'h06, 7'h2F
  };

  logic clock = 1'b0;
  logic reset = 1'b0;

  display_scan_if bus ();

  display_scan #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [5:0] words      [8];
  logic [5:0] model_snap [8];
  int         t;
  int         n_vec;
  int         n_err;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d after reset release)", tag, got, exp, t);
    end
  endtask

  task automatic drive();
    bus.d1 = words[0]; bus.d2 = words[1]; bus.d3 = words[2]; bus.d4 = words[3];
    bus.d5 = words[4]; bus.d6 = words[5]; bus.d7 = words[6]; bus.d8 = words[7];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_snap[i] = '0;
    t = 0;
  endtask

  // Outputs after edge t show the counter state reached at edge t-1.
  task automatic step();
    int         c, div, idx;
    logic [5:0] w;
    logic [7:0] an_e, seg_e;
    logic       tick_e;
    @(posedge clock);
    t++;
    c      = t - 1;
    div    = c % CLK_DIV;
    idx    = (c / CLK_DIV) % 8;
    w      = model_snap[idx];
    an_e   = 8'hFF;
    seg_e  = 8'hFF;
    if (div >= BLANK && w[5]) begin
      an_e  = ~(8'b1 << idx);
      seg_e = {w[0], glyph[w[4:1]]};
    end
    tick_e = (t % FRAME == 0);
    if (tick_e) for (int i = 0; i < 8; i++) model_snap[i] = words[i];
    #1;
    check("an", bus.an, an_e);
    check("seg", bus.seg, seg_e);
    check("frame_tick", {7'b0, bus.frame_tick}, {7'b0, tick_e});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, bus.an, 8'hFF);
    check({tag, "_seg"}, bus.seg, 8'hFF);
    check({tag, "_tick"}, {7'b0, bus.frame_tick}, 8'h00);
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    clear_model();
    for (int i = 0; i < 8; i++) words[i] = 6'($urandom);
    drive();

    repeat (5) begin
      @(posedge clock);
      #1;
      check_dark("in_reset");
    end
    @(negedge clock);
    reset = 1'b1;
    clear_model();

    // Scan order: enabled '0' everywhere; dark for the first frame, then the walk.
    for (int i = 0; i < 8; i++) words[i] = 6'b100001;
    drive();
    run(FRAME);

    // Symbols, blank digit, DP and a '7' on d3 for the next frame.
    run(20);
    words[7] = 6'b110111;
    words[6] = 6'b100011;
    words[5] = 6'b000000;
    words[4] = 6'b101011;
    words[2] = 6'b101111;
    words[0] = 6'b100000;
    drive();
    run(FRAME - 20);

    // No tearing: d3 becomes 'E' mid-frame and must wait for the next snapshot.
    run(30);
    words[2] = 6'b111101;
    drive();
    run(FRAME - 30);
    run(FRAME);

    repeat (6) begin
      for (int i = 0; i < 8; i++) words[i] = 6'($urandom);
      drive();
      k = $urandom_range(1, FRAME - 1);
      run(k);
      words[$urandom_range(0, 7)] = 6'($urandom);
      drive();
      run(FRAME - k);
    end

    // Asynchronous reset while slot 3 is lit, at a point where div has reached 5.
    for (int i = 0; i < 8; i++) words[i] = {1'b1, 5'($urandom)};
    drive();
    run(FRAME);
    run(3 * CLK_DIV + 5);
    #1;
    reset = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (3) begin
      @(posedge clock);
      #1;
      check_dark("held_reset");
    end
    @(negedge clock);
    reset = 1'b1;
    clear_model();

    for (int i = 0; i < 8; i++) words[i] = 6'($urandom);
    drive();
    run(FRAME);
    for (int i = 0; i < 8; i++) words[i] = 6'($urandom);
    drive();
    run(FRAME + 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
